sad_disparity_ctrl: RTL and testbench

Sequencer for the stereo block-matching datapath. For each reference pixel it sweeps candidate disparities 0..MAX_DISP-1 into the window-fetch/SAD pipeline, consumes the returned SAD values in order, tracks the running minimum, and emits the winning disparity per pixel on a valid/ready output. It sits between the pixel scheduler upstream and the disparity-map writer downstream, and owns the SAD unit exclusively.

---
 rtl/sad_disparity_ctrl_pkg.sv | 26 ++
 rtl/sad_disparity_ctrl_if.sv | 33 +++
 rtl/sad_disparity_ctrl_min_tracker.sv | 39 +++
 rtl/sad_disparity_ctrl.sv | 121 ++++++++++++
 tb/tb_sad_disparity_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sad_disparity_ctrl_pkg.sv
// Shared definitions for the stereo block-matching controller: FSM state
// type, default geometry and the width helpers used for parameter defaults.
package stereo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sad_ctrl_state_t;

    localparam int DEF_WIN      = 3;
    localparam int DEF_PIX_W    = 8;
    localparam int DEF_MAX_DISP = 64;

    // Bits needed to hold the largest possible SAD over a WIN x WIN window.
    function automatic int sad_width(input int win, input int pix_w);
        return $clog2(win * win * (2 ** pix_w - 1) + 1);
    endfunction

    // Disparity index width; a single-candidate sweep still needs one bit.
    function automatic int disp_width(input int max_disp);
        return (max_disp > 1) ? $clog2(max_disp) : 1;
    endfunction

endpackage

// File: rtl/sad_disparity_ctrl_if.sv
// Handshake bundle between the disparity controller and its neighbours:
// pixel scheduler, SAD pipeline and disparity-map writer.
interface sad_disparity_ctrl_if
    import stereo_pkg::*;
#(
    parameter int DISP_W = disp_width(DEF_MAX_DISP),
    parameter int SAD_W  = sad_width(DEF_WIN, DEF_PIX_W)
);
    logic              pix_valid;
    logic              pix_ready;
    logic              cand_valid;
    logic [DISP_W-1:0] cand_disp;
    logic              cand_ready;
    logic              sad_valid;
    logic [SAD_W-1:0]  sad_value;
    logic              disp_valid;
    logic [DISP_W-1:0] disp;
    logic [SAD_W-1:0]  disp_sad;
    logic              disp_ready;
    logic              busy;

    // Controller side.
    modport master (
        input  pix_valid, cand_ready, sad_valid, sad_value, disp_ready,
        output pix_ready, cand_valid, cand_disp, disp_valid, disp, disp_sad, busy
    );

    // Environment side (scheduler, SAD pipeline, writer).
    modport slave (
        output pix_valid, cand_ready, sad_valid, sad_value, disp_ready,
        input  pix_ready, cand_valid, cand_disp, disp_valid, disp, disp_sad, busy
    );
endinterface

// File: rtl/sad_disparity_ctrl_min_tracker.sv
// Running-minimum tracker: keeps the best SAD seen so far and the disparity
// that produced it. Strict less-than means ties keep the earliest index.
module sad_min_tracker
    import stereo_pkg::*;
#(
    parameter int DISP_W = 1,
    parameter int SAD_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_sad_valid,
    input  logic [SAD_W-1:0]  i_sad_value,
    input  logic [DISP_W-1:0] i_idx,
    output logic [DISP_W-1:0] o_best_disp,
    output logic [SAD_W-1:0]  o_best_sad
);
    logic [DISP_W-1:0] r_best_disp;
    logic [SAD_W-1:0]  r_best_sad;
    logic              w_better;

    assign w_better    = i_sad_valid && (i_sad_value < r_best_sad);
    assign o_best_disp = r_best_disp;
    assign o_best_sad  = r_best_sad;

    // Clear to "worse than anything" at job start, otherwise load on improvement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_disp <= '0;
            r_best_sad  <= '0;
        end else if (i_clear) begin
            r_best_disp <= '0;
            r_best_sad  <= '1;
        end else if (w_better) begin
            r_best_disp <= i_idx;
            r_best_sad  <= i_sad_value;
        end
    end
endmodule

// File: rtl/sad_disparity_ctrl.sv
// Disparity sweep sequencer: issues candidates 0..MAX_DISP-1 to the SAD
// pipeline, consumes results in order and reports the minimum-SAD disparity.
module sad_disparity_ctrl
    import stereo_pkg::*;
#(
    parameter int WIN      = DEF_WIN,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int MAX_DISP = DEF_MAX_DISP,
    parameter int DISP_W   = disp_width(MAX_DISP),
    parameter int SAD_W    = sad_width(WIN, PIX_W)
) (
    input logic                  clk,
    input logic                  rst_n,
    sad_disparity_ctrl_if.master bus
);
    localparam logic [DISP_W-1:0] LAST_IDX = DISP_W'(MAX_DISP - 1);

    sad_ctrl_state_t   r_state;
    logic              r_pix_ready;
    logic              r_cand_valid;
    logic              r_disp_valid;
    logic              r_busy;
    logic [DISP_W-1:0] r_issue_cnt;
    logic [DISP_W-1:0] r_res_cnt;

    logic              w_clear;
    logic              w_track;
    logic [DISP_W-1:0] w_best_disp;
    logic [SAD_W-1:0]  w_best_sad;

    // Results only count while a sweep is in flight; stray ones are dropped.
    assign w_clear = (r_state == ST_IDLE) && bus.pix_valid;
    assign w_track = bus.sad_valid && ((r_state == ST_ISSUE) || (r_state == ST_DRAIN));

    sad_min_tracker #(
        .DISP_W (DISP_W),
        .SAD_W  (SAD_W)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_clear),
        .i_sad_valid (w_track),
        .i_sad_value (bus.sad_value),
        .i_idx       (r_res_cnt),
        .o_best_disp (w_best_disp),
        .o_best_sad  (w_best_sad)
    );

    // Sweep FSM with issue/result counters and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_pix_ready  <= 1'b1;
            r_cand_valid <= 1'b0;
            r_disp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_issue_cnt  <= '0;
            r_res_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.pix_valid) begin
                        r_state      <= ST_ISSUE;
                        r_pix_ready  <= 1'b0;
                        r_cand_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_issue_cnt  <= '0;
                        r_res_cnt    <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (bus.cand_ready) begin
                        if (r_issue_cnt == LAST_IDX) begin
                            r_state      <= ST_DRAIN;
                            r_cand_valid <= 1'b0;
                        end else begin
                            r_issue_cnt <= r_issue_cnt + 1'b1;
                        end
                    end
                    // A final result here overrides the DRAIN move above.
                    if (bus.sad_valid) begin
                        if (r_res_cnt == LAST_IDX) begin
                            r_state      <= ST_DONE;
                            r_cand_valid <= 1'b0;
                            r_disp_valid <= 1'b1;
                        end else begin
                            r_res_cnt <= r_res_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.sad_valid) begin
                        if (r_res_cnt == LAST_IDX) begin
                            r_state      <= ST_DONE;
                            r_disp_valid <= 1'b1;
                        end else begin
                            r_res_cnt <= r_res_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.disp_ready) begin
                        r_state      <= ST_IDLE;
                        r_disp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_pix_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.pix_ready  = r_pix_ready;
    assign bus.cand_valid = r_cand_valid;
    assign bus.cand_disp  = r_issue_cnt;
    assign bus.disp_valid = r_disp_valid;
    assign bus.disp       = w_best_disp;
    assign bus.disp_sad   = w_best_sad;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_sad_disparity_ctrl.sv
// Bench for sad_disparity_ctrl: table-driven jobs, randomized jobs against a
// minimum-search reference, reset and single-candidate corner cases.
`timescale 1ns/1ps
module tb_sad_disparity_ctrl;
    import stereo_pkg::*;

    localparam int MD  = 8;
    localparam int DW  = 3;
    localparam int SW  = 12;
    localparam int DW1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sad_disparity_ctrl_if #(.DISP_W(DW),  .SAD_W(SW)) bus8();
    sad_disparity_ctrl_if #(.DISP_W(DW1), .SAD_W(SW)) bus1();

    sad_disparity_ctrl #(.WIN(3), .PIX_W(8), .MAX_DISP(MD), .DISP_W(DW), .SAD_W(SW)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8));
    sad_disparity_ctrl #(.WIN(3), .PIX_W(8), .MAX_DISP(1), .DISP_W(DW1), .SAD_W(SW)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));

    int errors = 0;
    int checks = 0;

    int job_sad [MD];
    int lat;
    int rdy_mode;

    typedef struct {
        int sads [MD];
        int mode;
        int hold;
        int exp_disp;
        int exp_sad;
        int exp_cyc;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One job on the 8-candidate instance with a latency-`lat` SAD pipeline model.
    task automatic run_job8(input int hold, output int o_disp, output int o_sad, output int o_cyc);
        int issued [MD];
        int q_disp [$];
        int q_due [$];
        int bad_issue;
        int stall_bad;
        logic prev_stall;
        logic [DW-1:0] prev_disp;
        bit got;
        foreach (issued[i]) issued[i] = 0;
        bad_issue = 0; stall_bad = 0; prev_stall = 1'b0; prev_disp = '0; got = 1'b0;
        o_disp = -1; o_sad = -1; o_cyc = -1;
        check("pix_ready_idle", 32'(bus8.pix_ready), 32'd1);
        bus8.pix_valid = 1'b1;
        tick();
        bus8.pix_valid = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            bus8.sad_valid  = 1'b0;
            bus8.cand_ready = 1'b0;
            if (bus8.disp_valid) begin
                got = 1'b1; o_cyc = cyc;
                o_disp = int'(bus8.disp); o_sad = int'(bus8.disp_sad);
                break;
            end
            case (rdy_mode)
                0:       bus8.cand_ready = 1'b1;
                1:       bus8.cand_ready = ((cyc - 1) % 3 == 0);
                default: bus8.cand_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus8.cand_valid && prev_stall && (bus8.cand_disp !== prev_disp)) stall_bad++;
            if (bus8.cand_valid && bus8.cand_ready) begin
                issued[int'(bus8.cand_disp)]++;
                q_disp.push_back(int'(bus8.cand_disp));
                q_due.push_back(cyc + lat);
            end
            prev_stall = bus8.cand_valid && !bus8.cand_ready;
            prev_disp  = bus8.cand_disp;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                if (bus8.pix_ready) begin
                    errors++;
                    $display("FAIL sad_protocol: sad_valid while idle");
                end
                bus8.sad_valid = 1'b1;
                bus8.sad_value = SW'(job_sad[q_disp.pop_front()]);
                void'(q_due.pop_front());
            end
            tick();
        end
        bus8.cand_ready = 1'b0;
        bus8.sad_valid  = 1'b0;
        foreach (issued[i]) if (issued[i] != 1) bad_issue++;
        check("done_seen", 32'(got), 32'd1);
        check("issue_once", 32'(bad_issue), 32'd0);
        check("stall_hold", 32'(stall_bad), 32'd0);
        if (got) begin
            for (int h = 0; h < hold; h++) begin
                tick();
                check("hold_disp", 32'(bus8.disp), 32'(o_disp));
                check("hold_sad", 32'(bus8.disp_sad), 32'(o_sad));
                check("hold_pix_ready", 32'(bus8.pix_ready), 32'd0);
                check("hold_valid", 32'(bus8.disp_valid), 32'd1);
            end
            bus8.disp_ready = 1'b1;
            tick();
            bus8.disp_ready = 1'b0;
            check("pix_ready_after", 32'(bus8.pix_ready), 32'd1);
            check("busy_after", 32'(bus8.busy), 32'd0);
        end
    endtask

    // One job on the single-candidate instance, pipeline latency 2.
    task automatic run_job1(input int sv, output int o_disp, output int o_sad, output int o_cyc);
        int due;
        int n_issue;
        bit pend;
        bit got;
        due = 0; n_issue = 0; pend = 1'b0; got = 1'b0;
        o_disp = -1; o_sad = -1; o_cyc = -1;
        check("j1_pix_ready_idle", 32'(bus1.pix_ready), 32'd1);
        bus1.pix_valid = 1'b1;
        tick();
        bus1.pix_valid = 1'b0;
        for (int cyc = 1; cyc < 50; cyc++) begin
            bus1.sad_valid  = 1'b0;
            bus1.cand_ready = 1'b1;
            if (bus1.disp_valid) begin
                got = 1'b1; o_cyc = cyc;
                o_disp = int'(bus1.disp); o_sad = int'(bus1.disp_sad);
                break;
            end
            if (bus1.cand_valid) begin
                n_issue++; pend = 1'b1; due = cyc + 2;
            end
            if (pend && due == cyc) begin
                bus1.sad_valid = 1'b1;
                bus1.sad_value = SW'(sv);
                pend = 1'b0;
            end
            tick();
        end
        bus1.sad_valid  = 1'b0;
        bus1.cand_ready = 1'b0;
        check("j1_done_seen", 32'(got), 32'd1);
        check("j1_issue_count", 32'(n_issue), 32'd1);
        bus1.disp_ready = 1'b1;
        tick();
        bus1.disp_ready = 1'b0;
        check("j1_pix_ready_after", 32'(bus1.pix_ready), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pix_ready"},  32'(bus8.pix_ready),  32'd1);
        check({tag, "_cand_valid"}, 32'(bus8.cand_valid), 32'd0);
        check({tag, "_cand_disp"},  32'(bus8.cand_disp),  32'd0);
        check({tag, "_disp_valid"}, 32'(bus8.disp_valid), 32'd0);
        check({tag, "_disp"},       32'(bus8.disp),       32'd0);
        check({tag, "_disp_sad"},   32'(bus8.disp_sad),   32'd0);
        check({tag, "_busy"},       32'(bus8.busy),       32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, s, c, ed, es;
        bus8.pix_valid = 0; bus8.cand_ready = 0; bus8.sad_valid = 0; bus8.sad_value = '0; bus8.disp_ready = 0;
        bus1.pix_valid = 0; bus1.cand_ready = 0; bus1.sad_valid = 0; bus1.sad_value = '0; bus1.disp_ready = 0;

        vecs[0] = '{sads: '{50, 40, 30, 35, 30, 60, 70, 80}, mode: 0, hold: 0, exp_disp: 2, exp_sad: 30, exp_cyc: 11};
        vecs[1] = '{sads: '{100, 100, 100, 100, 100, 100, 100, 100}, mode: 0, hold: 0, exp_disp: 0, exp_sad: 100, exp_cyc: 11};
        vecs[2] = '{sads: '{2295, 2295, 2295, 2295, 2295, 2295, 2295, 2295}, mode: 0, hold: 1, exp_disp: 0, exp_sad: 2295, exp_cyc: 11};
        vecs[3] = '{sads: '{50, 40, 30, 35, 30, 60, 70, 80}, mode: 1, hold: 0, exp_disp: 2, exp_sad: 30, exp_cyc: -1};
        vecs[4] = '{sads: '{9, 8, 7, 6, 5, 4, 3, 2}, mode: 0, hold: 5, exp_disp: 7, exp_sad: 2, exp_cyc: 11};
        vecs[5] = '{sads: '{1, 1, 1, 1, 1, 0, 1, 0}, mode: 1, hold: 2, exp_disp: 5, exp_sad: 0, exp_cyc: -1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table-driven jobs.
        lat = 2;
        for (int v = 0; v < 6; v++) begin
            foreach (job_sad[i]) job_sad[i] = vecs[v].sads[i];
            rdy_mode = vecs[v].mode;
            run_job8(vecs[v].hold, d, s, c);
            $display("vec %0d: disp=%0d sad=%0d cycle=%0d", v, d, s, c);
            check("vec_disp", 32'(d), 32'(vecs[v].exp_disp));
            check("vec_sad", 32'(s), 32'(vecs[v].exp_sad));
            if (vecs[v].exp_cyc >= 0) check("vec_cycle", 32'(c), 32'(vecs[v].exp_cyc));
        end

        // Reset in cycle 4 of a job.
        rdy_mode = 0;
        bus8.pix_valid = 1'b1;
        tick();
        bus8.pix_valid  = 1'b0;
        bus8.cand_ready = 1'b1;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        $display("mid-job reset applied");
        bus8.cand_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        foreach (job_sad[i]) job_sad[i] = vecs[0].sads[i];
        run_job8(0, d, s, c);
        $display("post-reset job: disp=%0d sad=%0d cycle=%0d", d, s, c);
        check("postrst_disp", 32'(d), 32'd2);
        check("postrst_sad", 32'(s), 32'd30);
        check("postrst_cycle", 32'(c), 32'd11);

        // Randomized jobs against a minimum-search reference.
        for (int j = 0; j < 24; j++) begin
            foreach (job_sad[i])
                job_sad[i] = (j % 2 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2295));
            lat = int'($urandom_range(1, 4));
            rdy_mode = (j % 3 == 0) ? 0 : 2;
            ed = 0; es = job_sad[0];
            for (int i = 1; i < MD; i++) if (job_sad[i] < es) begin es = job_sad[i]; ed = i; end
            run_job8(int'($urandom_range(0, 3)), d, s, c);
            $display("rand %0d: lat=%0d disp=%0d/%0d sad=%0d/%0d cycle=%0d", j, lat, d, ed, s, es, c);
            check("rand_disp", 32'(d), 32'(ed));
            check("rand_sad", 32'(s), 32'(es));
            if (rdy_mode == 0) check("rand_cycle", 32'(c), 32'(MD + lat + 1));
        end

        // Single-candidate instance, two back-to-back jobs.
        run_job1(7, d, s, c);
        $display("md1 job A: disp=%0d sad=%0d cycle=%0d", d, s, c);
        check("md1a_disp", 32'(d), 32'd0);
        check("md1a_sad", 32'(s), 32'd7);
        check("md1a_cycle", 32'(c), 32'd4);
        run_job1(3, d, s, c);
        $display("md1 job B: disp=%0d sad=%0d cycle=%0d", d, s, c);
        check("md1b_disp", 32'(d), 32'd0);
        check("md1b_sad", 32'(s), 32'd3);
        check("md1b_cycle", 32'(c), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
